fetch_buf_ctrl: RTL and testbench

//   Parametrised controller for the fetch line buffer between I-cache and decode. Generalises the
//   two-half fetch FSM to an NUM_ENT-entry circular buffer with per-entry load enables.

---
 rtl/fetch_buf_ctrl.sv | 106 ++++++++++
 tb/tb_fetch_buf_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_buf_ctrl.sv
// Fetch line-buffer controller: NUM_ENT-entry circular buffer between I-cache and decode,
// with redirect flush, simultaneous load/consume and registered occupancy status.
module fetch_buf_ctrl #(
  parameter int NUM_ENT = 4,
  parameter int PTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_hit,
  input  logic               r_V_de,
  input  logic               de_adv,
  input  logic               redirect,
  output logic               f_req,
  output logic [NUM_ENT-1:0] f_ld_buf,
  output logic               f_address_sel,
  output logic [NUM_ENT-1:0] buf_valid,
  output logic [PTR_W-1:0]   head_idx,
  output logic [PTR_W:0]     f_count,
  output logic [1:0]         f_curr_st
);

  if (PTR_W != $clog2(NUM_ENT)) begin : g_ptr_w_chk
    $error("fetch_buf_ctrl: PTR_W must equal log2(NUM_ENT)");
  end
  if ((NUM_ENT < 2) || ((NUM_ENT & (NUM_ENT - 1)) != 0)) begin : g_num_ent_chk
    $error("fetch_buf_ctrl: NUM_ENT must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_FULL  = 2'b10,
    ST_REDIR = 2'b11
  } state_t;

  state_t             r_st;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [NUM_ENT-1:0] r_valid;
  logic [PTR_W:0]     r_count;
  logic               r_addr_sel;

  logic               w_req;
  logic               w_ld;
  logic               w_cons;
  logic               w_flush;
  logic [PTR_W:0]     w_count_nxt;
  logic [NUM_ENT-1:0] w_valid_nxt;

  assign w_req       = (r_st == ST_FILL);
  assign w_ld        = w_req & ic_hit & ~redirect;
  assign w_cons      = de_adv & r_V_de & r_valid[r_head];
  assign w_flush     = redirect & (r_st != ST_IDLE);
  assign w_count_nxt = r_count + (PTR_W+1)'(w_ld) - (PTR_W+1)'(w_cons);

  // Load and pop never target the same valid entry: head==tail with a valid head means full,
  // and a full buffer is never in FILL, so the two updates below are independent.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_ld)   w_valid_nxt[r_tail] = 1'b1;
    if (w_cons) w_valid_nxt[r_head] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= ST_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_count    <= '0;
      r_addr_sel <= 1'b0;
    end else if (w_flush) begin
      r_st       <= ST_REDIR;
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_count    <= '0;
      r_addr_sel <= 1'b0;
    end else begin
      r_addr_sel <= w_ld;
      r_valid    <= w_valid_nxt;
      r_count    <= w_count_nxt;
      if (w_ld)   r_tail <= r_tail + 1'b1;
      if (w_cons) r_head <= r_head + 1'b1;
      unique case (r_st)
        ST_IDLE:  r_st <= ST_FILL;
        ST_FILL:  r_st <= (w_count_nxt == (PTR_W+1)'(NUM_ENT)) ? ST_FULL : ST_FILL;
        ST_FULL:  r_st <= w_cons ? ST_FILL : ST_FULL;
        ST_REDIR: r_st <= ST_FILL;
        default:  r_st <= ST_IDLE;
      endcase
    end
  end

  a_count_popcount: assert property (@(posedge clk) disable iff (rst)
    (r_count == (PTR_W+1)'($countones(r_valid))) && (r_count <= (PTR_W+1)'(NUM_ENT)));

  assign f_req         = w_req;
  assign f_ld_buf      = w_ld ? (NUM_ENT'(1) << r_tail) : '0;
  assign f_address_sel = r_addr_sel;
  assign buf_valid     = r_valid;
  assign head_idx      = r_head;
  assign f_count       = r_count;
  assign f_curr_st     = r_st;

endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// Scoreboard bench for fetch_buf_ctrl: directed per-cycle vectors push hand-computed
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_fetch_buf_ctrl;

  localparam int NUM_ENT = 4;
  localparam int PTR_W   = 2;

  localparam logic [1:0] IDLE = 2'b00, FILL = 2'b01, FULL = 2'b10, REDIR = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic               ic_hit;
  logic               r_V_de;
  logic               de_adv;
  logic               redirect;
  logic               f_req;
  logic [NUM_ENT-1:0] f_ld_buf;
  logic               f_address_sel;
  logic [NUM_ENT-1:0] buf_valid;
  logic [PTR_W-1:0]   head_idx;
  logic [PTR_W:0]     f_count;
  logic [1:0]         f_curr_st;

  fetch_buf_ctrl #(.NUM_ENT(NUM_ENT), .PTR_W(PTR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ic_hit        (ic_hit),
    .r_V_de        (r_V_de),
    .de_adv        (de_adv),
    .redirect      (redirect),
    .f_req         (f_req),
    .f_ld_buf      (f_ld_buf),
    .f_address_sel (f_address_sel),
    .buf_valid     (buf_valid),
    .head_idx      (head_idx),
    .f_count       (f_count),
    .f_curr_st     (f_curr_st)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic [2:0] cnt;
    logic [3:0] vld;
    logic [1:0] head;
    logic       req;
    logic [3:0] ld;
    logic       asel;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  task automatic chk(input int idx, input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", idx, name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.idx, "f_curr_st",     8'(f_curr_st),     8'(e.st));
        chk(e.idx, "f_count",       8'(f_count),       8'(e.cnt));
        chk(e.idx, "buf_valid",     8'(buf_valid),     8'(e.vld));
        chk(e.idx, "head_idx",      8'(head_idx),      8'(e.head));
        chk(e.idx, "f_req",         8'(f_req),         8'(e.req));
        chk(e.idx, "f_ld_buf",      8'(f_ld_buf),      8'(e.ld));
        chk(e.idx, "f_address_sel", 8'(f_address_sel), 8'(e.asel));
      end
    end
  end

  // One cycle: drive inputs after the edge, expect registered state from that edge plus
  // combinational outputs for these inputs.
  task automatic step(input logic i_rst, input logic i_hit, input logic i_vde, input logic i_adv,
                      input logic i_redir, input logic [1:0] st, input logic [2:0] cnt,
                      input logic [3:0] vld, input logic [1:0] head, input logic req,
                      input logic [3:0] ld, input logic asel);
    exp_t e;
    @(posedge clk);
    #1;
    rst = i_rst; ic_hit = i_hit; r_V_de = i_vde; de_adv = i_adv; redirect = i_redir;
    e.idx = n_step; e.st = st; e.cnt = cnt; e.vld = vld; e.head = head;
    e.req = req; e.ld = ld; e.asel = asel;
    exp_q.push_back(e);
    n_step++;
  endtask

  initial begin
    rst = 1'b1; ic_hit = 1'b0; r_V_de = 1'b0; de_adv = 1'b0; redirect = 1'b0;
    //    rst  hit  vde  adv  rdr   st     cnt   vld      hd   req  ld       asel
    // 1: reset, continuous hits, fill to FULL
    step(0, 1, 0, 0, 0,  IDLE,  3'd0, 4'b0000, 2'd0, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd0, 4'b0000, 2'd0, 1, 4'b0001, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd1, 4'b0001, 2'd0, 1, 4'b0010, 1);
    step(0, 1, 0, 0, 0,  FILL,  3'd2, 4'b0011, 2'd0, 1, 4'b0100, 1);
    step(0, 1, 0, 0, 0,  FILL,  3'd3, 4'b0111, 2'd0, 1, 4'b1000, 1);
    step(0, 1, 0, 0, 0,  FULL,  3'd4, 4'b1111, 2'd0, 0, 4'b0000, 1);
    // 2: consume from full, reload entry 0 via tail wrap
    step(0, 1, 1, 1, 0,  FULL,  3'd4, 4'b1111, 2'd0, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd3, 4'b1110, 2'd1, 1, 4'b0001, 0);
    step(0, 0, 0, 0, 0,  FULL,  3'd4, 4'b1111, 2'd1, 0, 4'b0000, 1);
    // 3: drain to 2, then simultaneous load and consume
    step(0, 0, 1, 1, 0,  FULL,  3'd4, 4'b1111, 2'd1, 0, 4'b0000, 0);
    step(0, 0, 1, 1, 0,  FILL,  3'd3, 4'b1101, 2'd2, 1, 4'b0000, 0);
    step(0, 1, 1, 1, 0,  FILL,  3'd2, 4'b1001, 2'd3, 1, 4'b0010, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd2, 4'b0011, 2'd0, 1, 4'b0100, 1);
    // 4: redirect with concurrent hit at count 3
    step(0, 1, 0, 0, 1,  FILL,  3'd3, 4'b0111, 2'd0, 1, 4'b0000, 1);
    step(0, 1, 0, 0, 0,  REDIR, 3'd0, 4'b0000, 2'd0, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd0, 4'b0000, 2'd0, 1, 4'b0001, 0);
    step(0, 0, 0, 0, 0,  FILL,  3'd1, 4'b0001, 2'd0, 1, 4'b0000, 1);
    // 5: de_adv without r_V_de, real pop, then de_adv on empty buffer
    step(0, 0, 0, 1, 0,  FILL,  3'd1, 4'b0001, 2'd0, 1, 4'b0000, 0);
    step(0, 0, 1, 1, 0,  FILL,  3'd1, 4'b0001, 2'd0, 1, 4'b0000, 0);
    step(0, 0, 1, 1, 0,  FILL,  3'd0, 4'b0000, 2'd1, 1, 4'b0000, 0);
    // 6: refill from head 1 to FULL, then reset mid-FULL with de_adv
    step(0, 1, 0, 0, 0,  FILL,  3'd0, 4'b0000, 2'd1, 1, 4'b0010, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd1, 4'b0010, 2'd1, 1, 4'b0100, 1);
    step(0, 1, 0, 0, 0,  FILL,  3'd2, 4'b0110, 2'd1, 1, 4'b1000, 1);
    step(0, 1, 0, 0, 0,  FILL,  3'd3, 4'b1110, 2'd1, 1, 4'b0001, 1);
    step(1, 0, 1, 1, 0,  FULL,  3'd4, 4'b1111, 2'd1, 0, 4'b0000, 1);
    // redirect in IDLE is ignored; tail restarts at entry 0 after reset
    step(0, 0, 0, 0, 1,  IDLE,  3'd0, 4'b0000, 2'd0, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 0,  FILL,  3'd0, 4'b0000, 2'd0, 1, 4'b0001, 0);
    step(0, 0, 0, 0, 0,  FILL,  3'd1, 4'b0001, 2'd0, 1, 4'b0000, 1);

    begin : drain
      int unsigned budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
